// File: rtl/spad_pingpong_acc_if.sv
// Bundled write/read/handshake signals of the ping-pong scratchpad.
// o_sat exists only when SPAD_SAT_ACC_EN is defined.
interface spad_pingpong_acc_if #(
    parameter int DATA_BITWIDTH = 16,
    parameter int ADDR_BITWIDTH = 9
) ();
    logic                     i_wen;
    logic                     i_wacc;
    logic [ADDR_BITWIDTH-1:0] i_waddr;
    logic [DATA_BITWIDTH-1:0] i_wdata;
    logic                     i_wlast;
    logic                     o_wready;
    logic                     o_werr;
    logic                     o_wbank;
    logic                     i_ren;
    logic [ADDR_BITWIDTH-1:0] i_raddr;
    logic [DATA_BITWIDTH-1:0] o_rdata;
    logic                     o_rvalid;
    logic                     i_rrelease;
    logic                     o_rready;
    logic                     o_rbank;
`ifdef SPAD_SAT_ACC_EN
    logic                     o_sat;
`endif

    modport slave (
        input  i_wen, i_wacc, i_waddr, i_wdata, i_wlast,
        input  i_ren, i_raddr, i_rrelease,
        output o_wready, o_werr, o_wbank,
        output o_rdata, o_rvalid, o_rready, o_rbank
`ifdef SPAD_SAT_ACC_EN
        , output o_sat
`endif
    );

    modport master (
        output i_wen, i_wacc, i_waddr, i_wdata, i_wlast,
        output i_ren, i_raddr, i_rrelease,
        input  o_wready, o_werr, o_wbank,
        input  o_rdata, o_rvalid, o_rready, o_rbank
`ifdef SPAD_SAT_ACC_EN
        , input o_sat
`endif
    );
endinterface

// File: rtl/spad_pingpong_acc.sv
// Double-buffered PE scratchpad: writer fills/accumulates one bank while the reader drains the other.
// Define SPAD_SAT_ACC_EN for signed saturating accumulate with an o_sat pulse.
module spad_pingpong_acc #(
    parameter int DATA_BITWIDTH = 16,
    parameter int ADDR_BITWIDTH = 9
) (
    input  logic                    clk,
    input  logic                    reset,
    spad_pingpong_acc_if.slave      bus
);
    localparam int MEM_WORDS = 2 << ADDR_BITWIDTH;
    localparam int MSB       = DATA_BITWIDTH - 1;

    typedef logic [DATA_BITWIDTH-1:0] word_t;

    function automatic word_t acc_sum(input word_t a, input word_t b);
        word_t sum;
        sum = a + b;
`ifdef SPAD_SAT_ACC_EN
        // Same-sign operands producing an opposite-sign sum overflowed: clamp toward the operand sign.
        if ((a[MSB] == b[MSB]) && (sum[MSB] != a[MSB])) begin
            sum = a[MSB] ? {1'b1, {(DATA_BITWIDTH-1){1'b0}}} : {1'b0, {(DATA_BITWIDTH-1){1'b1}}};
        end else begin
            sum = sum;
        end
`endif
        return sum;
    endfunction

`ifdef SPAD_SAT_ACC_EN
    function automatic logic acc_clamped(input word_t a, input word_t b);
        word_t sum;
        sum = a + b;
        return (a[MSB] == b[MSB]) && (sum[MSB] != a[MSB]);
    endfunction
`endif

    word_t      mem_q [MEM_WORDS];
    logic [1:0] full_q, full_d;
    logic       wptr_q, wptr_d;
    logic       rptr_q, rptr_d;
    word_t      rdata_q, rdata_d;
    logic       rvalid_q, rvalid_d;
    logic       werr_q, werr_d;
`ifdef SPAD_SAT_ACC_EN
    logic       sat_q, sat_d;
`endif

    logic                     wready, rready;
    logic                     wr_fire, commit_fire, rel_fire, rd_fire;
    logic [ADDR_BITWIDTH:0]   mem_waddr, mem_raddr;
    word_t                    mem_old, mem_wdata;

    // Handshake decode and next-state for bank ownership, read pipe and error/sat pulses.
    always_comb begin
        wready      = !full_q[wptr_q];
        rready      = full_q[rptr_q];
        wr_fire     = bus.i_wen && wready;
        commit_fire = bus.i_wlast && wready;
        rel_fire    = bus.i_rrelease && rready;
        rd_fire     = bus.i_ren && rready;

        mem_waddr = {wptr_q, bus.i_waddr};
        mem_raddr = {rptr_q, bus.i_raddr};
        mem_old   = mem_q[mem_waddr];
        mem_wdata = bus.i_wacc ? acc_sum(mem_old, bus.i_wdata) : bus.i_wdata;

        // Commit and release never touch the same bit in a conflicting way, so both apply together.
        full_d = (full_q | (commit_fire ? (2'b01 << wptr_q) : 2'b00))
               & ~(rel_fire ? (2'b01 << rptr_q) : 2'b00);
        wptr_d = wptr_q ^ commit_fire;
        rptr_d = rptr_q ^ rel_fire;

        werr_d   = (bus.i_wen || bus.i_wlast) && !wready;
        rvalid_d = rd_fire;
        rdata_d  = rd_fire ? mem_q[mem_raddr] : {DATA_BITWIDTH{1'b0}};
`ifdef SPAD_SAT_ACC_EN
        sat_d    = wr_fire && bus.i_wacc && acc_clamped(mem_old, bus.i_wdata);
`endif
    end

    // Control and output registers; reset clears ownership and ignores all requests that cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            full_q   <= 2'b00;
            wptr_q   <= 1'b0;
            rptr_q   <= 1'b0;
            rdata_q  <= {DATA_BITWIDTH{1'b0}};
            rvalid_q <= 1'b0;
            werr_q   <= 1'b0;
`ifdef SPAD_SAT_ACC_EN
            sat_q    <= 1'b0;
`endif
        end else begin
            full_q   <= full_d;
            wptr_q   <= wptr_d;
            rptr_q   <= rptr_d;
            rdata_q  <= rdata_d;
            rvalid_q <= rvalid_d;
            werr_q   <= werr_d;
`ifdef SPAD_SAT_ACC_EN
            sat_q    <= sat_d;
`endif
        end
    end

    // Scratchpad storage, deliberately not reset.
    always_ff @(posedge clk) begin
        if (!reset && wr_fire) begin
            mem_q[mem_waddr] <= mem_wdata;
        end
    end

    assign bus.o_wready = wready;
    assign bus.o_rready = rready;
    assign bus.o_wbank  = wptr_q;
    assign bus.o_rbank  = rptr_q;
    assign bus.o_werr   = werr_q;
    assign bus.o_rdata  = rdata_q;
    assign bus.o_rvalid = rvalid_q;
`ifdef SPAD_SAT_ACC_EN
    assign bus.o_sat    = sat_q;
`endif
endmodule

// File: tb/tb_spad_pingpong_acc.sv
// Directed self-checking bench for spad_pingpong_acc (16-bit data, 9-bit address).
// Saturation expectations follow SPAD_SAT_ACC_EN.
module tb_spad_pingpong_acc;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int   total_cnt = 0;
    int   pass_cnt  = 0;

    spad_pingpong_acc_if #(.DATA_BITWIDTH(16), .ADDR_BITWIDTH(9)) bus ();

    spad_pingpong_acc #(.DATA_BITWIDTH(16), .ADDR_BITWIDTH(9)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    endtask

    task automatic idle();
        bus.i_wen = 1'b0; bus.i_wacc = 1'b0; bus.i_waddr = 9'd0; bus.i_wdata = 16'd0;
        bus.i_wlast = 1'b0; bus.i_ren = 1'b0; bus.i_raddr = 9'd0; bus.i_rrelease = 1'b0;
    endtask

    initial begin
        idle();
        tick();
        // Requests during reset must be ignored.
        bus.i_wen = 1'b1; bus.i_wdata = 16'd999; bus.i_wlast = 1'b1; bus.i_ren = 1'b1;
        tick();
        reset = 1'b0;
        idle();
        chk("rst_wready", 32'(bus.o_wready), 32'd1);
        chk("rst_rready", 32'(bus.o_rready), 32'd0);
        chk("rst_wbank",  32'(bus.o_wbank),  32'd0);
        chk("rst_rbank",  32'(bus.o_rbank),  32'd0);
        chk("rst_rdata",  32'(bus.o_rdata),  32'd0);
        chk("rst_rvalid", 32'(bus.o_rvalid), 32'd0);
        chk("rst_werr",   32'(bus.o_werr),   32'd0);

        // Bank 0: addr 0..3 = 10,20,30,40, commit with the last write.
        for (int i = 0; i < 4; i++) begin
            bus.i_wen = 1'b1; bus.i_waddr = 9'(i); bus.i_wdata = 16'(10 * (i + 1));
            bus.i_wlast = (i == 3);
            tick();
            chk("fill0_wready", 32'(bus.o_wready), 32'd1);
        end
        idle();
        chk("commit0_wbank",  32'(bus.o_wbank),  32'd1);
        chk("commit0_rready", 32'(bus.o_rready), 32'd1);
        chk("commit0_rbank",  32'(bus.o_rbank),  32'd0);

        bus.i_ren = 1'b1; bus.i_raddr = 9'd2;
        tick();
        idle();
        chk("rd0_a2_data",  32'(bus.o_rdata),  32'd30);
        chk("rd0_a2_valid", 32'(bus.o_rvalid), 32'd1);
        tick();
        chk("rd_idle_data",  32'(bus.o_rdata),  32'd0);
        chk("rd_idle_valid", 32'(bus.o_rvalid), 32'd0);

        // Bank 1: addr0 = 2989, addr5 = 100 then +7 three times back to back.
        bus.i_wen = 1'b1; bus.i_waddr = 9'd0; bus.i_wdata = 16'd2989;
        tick();
        bus.i_waddr = 9'd5; bus.i_wdata = 16'd100;
        tick();
        bus.i_wacc = 1'b1; bus.i_wdata = 16'd7;
        tick();
        tick();
        tick();
        idle();
        chk("acc_wbank", 32'(bus.o_wbank), 32'd1);

        // full=01, wptr=1, rptr=0: commit + release + read addr 0 together.
        bus.i_wlast = 1'b1; bus.i_rrelease = 1'b1; bus.i_ren = 1'b1; bus.i_raddr = 9'd0;
        tick();
        idle();
        chk("swap_wbank",  32'(bus.o_wbank),  32'd0);
        chk("swap_rbank",  32'(bus.o_rbank),  32'd1);
        chk("swap_rready", 32'(bus.o_rready), 32'd1);
        chk("swap_wready", 32'(bus.o_wready), 32'd1);
        chk("swap_rdata",  32'(bus.o_rdata),  32'd10);
        chk("swap_rvalid", 32'(bus.o_rvalid), 32'd1);

        bus.i_ren = 1'b1; bus.i_raddr = 9'd5;
        tick();
        idle();
        chk("acc_result", 32'(bus.o_rdata), 32'd121);

        // Write + commit bank 0 in one cycle: both banks full.
        bus.i_wen = 1'b1; bus.i_waddr = 9'd7; bus.i_wdata = 16'h1234; bus.i_wlast = 1'b1;
        tick();
        idle();
        chk("both_full_wready", 32'(bus.o_wready), 32'd0);
        chk("both_full_wbank",  32'(bus.o_wbank),  32'd1);
        chk("both_full_werr",   32'(bus.o_werr),   32'd0);

        bus.i_wen = 1'b1; bus.i_waddr = 9'd0; bus.i_wdata = 16'd55;
        tick();
        idle();
        chk("werr_wen_pulse", 32'(bus.o_werr), 32'd1);
        tick();
        chk("werr_wen_clear", 32'(bus.o_werr), 32'd0);
        bus.i_wlast = 1'b1;
        tick();
        idle();
        chk("werr_wlast_pulse", 32'(bus.o_werr),  32'd1);
        chk("werr_wlast_wbank", 32'(bus.o_wbank), 32'd1);
        tick();
        chk("werr_wlast_clear", 32'(bus.o_werr), 32'd0);

        bus.i_ren = 1'b1; bus.i_raddr = 9'd0;
        tick();
        idle();
        chk("werr_mem_kept", 32'(bus.o_rdata), 32'd2989);

        // Release bank 1: writer regains exactly that bank.
        bus.i_rrelease = 1'b1;
        tick();
        idle();
        chk("rel1_wready", 32'(bus.o_wready), 32'd1);
        chk("rel1_wbank",  32'(bus.o_wbank),  32'd1);
        chk("rel1_rbank",  32'(bus.o_rbank),  32'd0);
        chk("rel1_rready", 32'(bus.o_rready), 32'd1);
        bus.i_ren = 1'b1; bus.i_raddr = 9'd7;
        tick();
        idle();
        chk("commit_wr_landed", 32'(bus.o_rdata), 32'h1234);

        // Release bank 0: both empty.
        bus.i_rrelease = 1'b1;
        tick();
        idle();
        chk("empty_rready", 32'(bus.o_rready), 32'd0);
        chk("empty_rbank",  32'(bus.o_rbank),  32'd1);
        bus.i_ren = 1'b1; bus.i_raddr = 9'd0;
        tick();
        idle();
        chk("empty_rd_data",  32'(bus.o_rdata),  32'd0);
        chk("empty_rd_valid", 32'(bus.o_rvalid), 32'd0);
        bus.i_rrelease = 1'b1;
        tick();
        idle();
        chk("empty_rel_rbank",  32'(bus.o_rbank),  32'd1);
        chk("empty_rel_rready", 32'(bus.o_rready), 32'd0);
        chk("empty_rel_wready", 32'(bus.o_wready), 32'd1);

        // Accumulate overflow: 32760 + 100 in bank 1.
        bus.i_wen = 1'b1; bus.i_waddr = 9'd9; bus.i_wdata = 16'd32760;
        tick();
        bus.i_wacc = 1'b1; bus.i_wdata = 16'd100;
        tick();
        idle();
`ifdef SPAD_SAT_ACC_EN
        chk("sat_pulse", 32'(bus.o_sat), 32'd1);
        tick();
        chk("sat_clear", 32'(bus.o_sat), 32'd0);
`endif
        bus.i_wlast = 1'b1;
        tick();
        idle();
        chk("ovf_commit_rready", 32'(bus.o_rready), 32'd1);
        bus.i_ren = 1'b1; bus.i_raddr = 9'd9;
        tick();
        idle();
`ifdef SPAD_SAT_ACC_EN
        chk("ovf_result", 32'(bus.o_rdata), 32'h7FFF);
`else
        chk("ovf_result", 32'(bus.o_rdata), 32'h805C);
`endif

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule

// File: doc/spad_pingpong_acc.md
Name: spad_pingpong_acc

Overview:
- Double-buffered (ping-pong) scratchpad for PE-local operands and partial sums.
- The writer fills or accumulates into one bank while the reader drains the other; banks swap ownership via commit/release handshakes.
- Write side supports plain write or read-modify-write accumulate for psum reuse.
- Read side has registered 1-cycle latency; output is zero when idle.

Parameters:
- DATA_BITWIDTH, 16, word width (two's-complement when accumulating).
- ADDR_BITWIDTH, 9, per-bank address width; each bank holds 1<<ADDR_BITWIDTH words.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- i_wen  in  1  write strobe
- i_wacc  in  1  1 = accumulate (mem += wdata), 0 = overwrite; sampled with i_wen
- i_waddr  in  ADDR_BITWIDTH  write/accumulate address in the write bank
- i_wdata  in  DATA_BITWIDTH  write data / addend
- i_wlast  in  1  commit write bank as full (may coincide with i_wen)
- o_wready  out  1  write bank is not full
- o_werr  out  1  1-cycle pulse: write or commit attempted while !o_wready
- o_wbank  out  1  index of the current write bank
- i_ren  in  1  read strobe
- i_raddr  in  ADDR_BITWIDTH  read address in the read bank
- o_rdata  out  DATA_BITWIDTH  registered read data
- o_rvalid  out  1  o_rdata is valid
- i_rrelease  in  1  release read bank back to the writer
- o_rready  out  1  read bank is full and readable
- o_rbank  out  1  index of the current read bank

Behaviour:
- State:
  - full[1:0] flags; wptr and rptr (1 bit each).
  - Memory is 2 x (1<<ADDR_BITWIDTH) x DATA_BITWIDTH and is not reset.
- Reset (synchronous, clk edge with reset=1):
  - full=00, wptr=0, rptr=0.
  - o_rdata=0, o_rvalid=0, o_werr=0.
  - All write/read/commit/release inputs are ignored that cycle.
  - Reset mid-fill discards all bank state; memory contents are retained but treated as stale.
- Combinational outputs:
  - o_wready = !full[wptr]; o_rready = full[rptr].
  - o_wbank = wptr; o_rbank = rptr.
- Write, when i_wen && o_wready:
  - i_wacc=0: mem[wptr][i_waddr] <= i_wdata.
  - i_wacc=1: mem[wptr][i_waddr] <= mem[wptr][i_waddr] + i_wdata, truncated to DATA_BITWIDTH (wrap).
  - Back-to-back accumulates to the same address each see the prior cycle's result; there is no hazard.
- Commit, when i_wlast && o_wready:
  - full[wptr] <= 1 and wptr <= ~wptr.
  - A write in the same cycle lands in the old bank before the swap.
- Write-side error: i_wen or i_wlast while !o_wready:
  - No memory or state change.
  - o_werr=1 on the next cycle for exactly 1 cycle.
- Read, when i_ren && o_rready:
  - Next cycle: o_rdata = mem[rptr][i_raddr], o_rvalid=1.
  - Otherwise next cycle: o_rdata=0, o_rvalid=0.
  - Latency is exactly 1 cycle; full throughput of one read per cycle.
- Release, when i_rrelease && o_rready:
  - full[rptr] <= 0 and rptr <= ~rptr.
  - A read in the same cycle uses the old bank and is still returned next cycle.
  - Release while !o_rready is ignored.
- Simultaneous commit and release:
  - They always target different banks, or the same bank in opposite states; both take effect in the same cycle.
  - Example: full=01, wptr=1, rptr=0 with commit+release -> full=10, wptr=0, rptr=1.
- Both banks full: o_wready=0 until a release occurs.
- Both banks empty: o_rready=0; reads return 0 with o_rvalid=0.
- No read/write collision exists, because the write bank and the read bank are never both accessible at once.

Optional Feature:
- Macro SPAD_SAT_ACC_EN.
- Defined: accumulate is signed saturating.
  - Result is clamped to [-(2^(DATA_BITWIDTH-1)), 2^(DATA_BITWIDTH-1)-1].
  - Output o_sat (1 bit) pulses for 1 cycle on the cycle after any clamped accumulate.
- Not defined: modular wrap on accumulate, and no o_sat port.

Test Plan:
- Reset, then write addr 0..3 = 10,20,30,40 with i_wlast on the 4th -> o_wready stays 1, o_wbank=1, o_rready=1. Read addr 2 -> next cycle o_rdata=30, o_rvalid=1.
- Overwrite addr 5=100, then accumulate addr 5 by +7 on three consecutive cycles, commit, read addr 5 -> 121.
- Fill and commit both banks -> o_wready=0. i_wen to addr 0 with data 55 -> o_werr pulses 1 cycle and memory is unchanged. Release -> o_wready=1, o_wbank equals the released bank.
- Read with o_rready=0 -> o_rdata=0, o_rvalid=0. i_rrelease with o_rready=0 -> full/rptr unchanged.
- With full=01, wptr=1, rptr=0, assert i_wlast, i_rrelease and i_ren(addr 0) in the same cycle:
  - full becomes 10, wptr=0, rptr=1.
  - Next cycle o_rdata = old bank-0 addr 0.
- With DATA_BITWIDTH=16, SPAD_SAT_ACC_EN defined: overwrite 32760 then accumulate +100 -> 32767 and o_sat=1. Without the macro the same sequence -> -32676.
